fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Front-end controller for the single-cycle core's PC register. It owns the PC register's `pc_in` and computes the next PC every cycle: hold, PC+4, branch/jump redirect, or trap vector. It also runs the req/ack handshake to instruction memory and presents one fetched instruction at a time to decode with a valid/ready handshake.

## Interface
**Parameters**
- `RESET_VECTOR`, default 32'h8000_0000: first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `instr` when no instruction is held.

**Ports**
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `pc_q`  in  32: current PC from the PC register.
- `pc_plus4`  in  32: PC+4 from the PC register's adder.
- `pc_next`  out  32: drives the PC register's `pc_in`; the register loads it every cycle.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address.
- `imem_ack`  in  1: response valid; a transfer completes on `imem_req & imem_ack`.
- `imem_rdata`  in  32: instruction word, valid with `imem_ack`.
- `instr_valid`  out  1: `instr`/`instr_pc` are valid for decode.
- `instr`  out  32: held instruction.
- `instr_pc`  out  32: address of the held instruction.
- `instr_ready`  in  1: decode consumes the instruction on `instr_valid & instr_ready`.
- `redirect_valid`  in  1: taken branch or jump.
- `redirect_target`  in  32: redirect address.
- `trap_valid`  in  1: trap request.
- `trap_vector`  in  32: trap handler address.
- `halt`  in  1: stop fetching after the current instruction is consumed.
- `align_err`  out  1: one-cycle pulse when an accepted target has bits [1:0] ≠ 0.

## Operation
- States: FETCH, VALID, HALTED.
- **Reset:** state=FETCH, `pc_next`=RESET_VECTOR, `imem_req`=0, `instr_valid`=0, `instr`=NOP_INSTR, `instr_pc`=0, pending-redirect flag clear, `align_err`=0.
- **Default:** `pc_next`=`pc_q` (hold) unless a rule below applies.
- **FETCH:**
  - `imem_req`=1 and `imem_addr`=`pc_q`. The address is held stable until ack.
  - On ack with no pending redirect: capture `imem_rdata` into `instr` and `pc_q` into `instr_pc`, then go to VALID.
- **Redirect or trap during FETCH without ack:**
  - Latch the target into the pending register; trap overwrites redirect.
  - Keep requesting the old address.
- **Ack while pending:**
  - Discard the response.
  - `pc_next`=pending target; clear pending; stay in FETCH.
- **Redirect or trap in the same cycle as ack:**
  - Discard the response.
  - `pc_next`=new target; stay in FETCH.
- **VALID:**
  - `instr_valid`=1 and `imem_req`=0.
  - Next-PC priority: trap > redirect > consume.
  - Trap or redirect: drop the instruction (`instr_valid`=0 next cycle), `pc_next`=target, go to FETCH.
  - `instr_ready` with no redirect: `pc_next`=`pc_plus4`, go to FETCH.
  - If `halt`=1 at consume, go to HALTED instead.
- **HALTED:**
  - `imem_req`=0, `instr_valid`=0, `pc_next`=`pc_q`.
  - Redirect and trap are ignored; only reset exits.
- **Alignment:**
  - Every accepted target is forced to `{target[31:2],2'b00}`.
  - `align_err` pulses in the cycle the target is accepted.
- **Arithmetic:** 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC+4 → 0.
- `halt` is sampled only at consume.

## Timing
- **Zero-wait memory:** ack in the first FETCH cycle → VALID next cycle.
- With `instr_ready`=1, the next FETCH starts the cycle after. Throughput is 1 instruction per 2 cycles.
- `pc_next` is combinational from the state and inputs. The PC register updates on the next edge.
- `instr`, `instr_pc`, `instr_valid` and the state are registered.
- `imem_req` and `imem_addr` are combinational from the state and `pc_q`.
- **Redirect latency:** the first fetch at the target is requested 1 cycle after redirect acceptance (from VALID), or 1 cycle after the discarded ack (from FETCH).
- **Reset mid-fetch:**
  - Outstanding acks are ignored; `imem_req`=0 during reset.
  - The first request after reset uses RESET_VECTOR.

## Structure
- **Shared `rv32i_pkg`:**
  - `fetch_state_e` enum (FETCH, VALID, HALTED).
  - NOP constant.
  - Reset vector constant; the same value is also used by the PC register's reset.
- **Sub-module `redirect_pending`:** 1-entry target register with priority merge (trap over redirect) and clear-on-ack.

## Test plan
- **Reset then zero-wait memory:** with `instr_ready`=1, `imem_addr` sequence is 0x8000_0000, 0x8000_0004, 0x8000_0008, and `instr_valid` pulses every 2nd cycle.
- **Memory wait of 3 cycles:** `imem_addr` stays stable, `pc_next`=`pc_q` throughout, and `instr` is captured on the ack cycle.
- **Redirect to 0x8000_0100 in FETCH, ack 2 cycles later:** the response is discarded, no `instr_valid`, and the next request is 0x8000_0100.
- **Trap (0x8000_0200) and redirect (0x8000_0300) simultaneously in VALID:** the instruction is dropped and the next `imem_addr` is 0x8000_0200.
- **Redirect target 0x8000_0102:** `align_err` pulses for 1 cycle and the next fetch is at 0x8000_0100.
- **`halt` at consume, then a redirect:** stays in HALTED with `imem_req`=0 and `pc_q` frozen. Reset then restarts at 0x8000_0000.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, NOP encoding, reset vector
// and word-alignment helpers used by the fetch path and the PC register.
package rv32i_pkg;

  localparam logic [31:0] RV_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] RV_NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    VALID  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/redirect_pending.sv
// One-entry holding register for a redirect/trap target that arrives while a fetch
// is outstanding; merges new requests with the held one (trap beats redirect).
module redirect_pending
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        active,
  input  logic        imem_ack,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  output logic        target_valid,
  output logic [31:0] target,
  output logic        accept,
  output logic        accept_misaligned
);

  logic        pend_valid_q;
  logic        pend_trap_q;
  logic [31:0] pend_target_q;
  logic        take_redirect;
  logic [31:0] new_raw;

  // A held trap must not be displaced by a later plain redirect.
  assign take_redirect     = redirect_valid & ~(pend_valid_q & pend_trap_q);
  assign accept            = active & (trap_valid | take_redirect);
  assign new_raw           = trap_valid ? trap_vector : redirect_target;
  assign accept_misaligned = accept & is_misaligned(new_raw);
  assign target_valid      = accept | pend_valid_q;
  assign target            = accept ? align_word(new_raw) : pend_target_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_trap_q  <= 1'b0;
    end else if (active) begin
      if (imem_ack) begin
        pend_valid_q <= 1'b0;
        pend_trap_q  <= 1'b0;
      end else if (accept) begin
        pend_valid_q <= 1'b1;
        pend_trap_q  <= trap_valid;
      end
    end
  end

  // NOTE: the target word needs no reset; it is never read while pend_valid_q is clear.
  always_ff @(posedge clk) begin
    if (active && !imem_ack && accept) begin
      pend_target_q <= align_word(new_raw);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end controller: drives the PC register's next value, runs the imem req/ack
// handshake and hands one instruction at a time to decode.
module fetch_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RV_RESET_VECTOR,
  parameter logic [31:0] NOP_INSTR    = RV_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_q,
  input  logic [31:0] pc_plus4,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_vector,
  input  logic        halt,
  output logic        align_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_pc_q;
  logic         load_instr, drop_instr;
  logic         fetch_active;
  logic         pend_hit, pend_accept, pend_misaligned;
  logic [31:0]  pend_target;
  logic [31:0]  sel_target;

  assign fetch_active = (state_q == FETCH);

  redirect_pending u_pending (
    .clk               (clk),
    .rst_n             (rst_n),
    .active            (fetch_active),
    .imem_ack          (imem_ack),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .trap_valid        (trap_valid),
    .trap_vector       (trap_vector),
    .target_valid      (pend_hit),
    .target            (pend_target),
    .accept            (pend_accept),
    .accept_misaligned (pend_misaligned)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    state_d    = state_q;
    pc_next    = pc_q;
    imem_req   = 1'b0;
    align_err  = 1'b0;
    load_instr = 1'b0;
    drop_instr = 1'b0;
    sel_target = trap_valid ? trap_vector : redirect_target;

    case (state_q)
      FETCH: begin
        imem_req  = 1'b1;
        align_err = pend_accept & pend_misaligned;
        if (imem_ack) begin
          // A response racing a redirect belongs to the abandoned path.
          if (pend_hit) begin
            pc_next = pend_target;
          end else begin
            load_instr = 1'b1;
            state_d    = VALID;
          end
        end
      end
      VALID: begin
        if (trap_valid || redirect_valid) begin
          pc_next    = align_word(sel_target);
          align_err  = is_misaligned(sel_target);
          drop_instr = 1'b1;
          state_d    = FETCH;
        end else if (instr_ready) begin
          pc_next    = pc_plus4;
          drop_instr = 1'b1;
          state_d    = halt ? HALTED : FETCH;
        end
      end
      default: ;
    endcase

    if (!rst_n) begin
      pc_next   = RESET_VECTOR;
      imem_req  = 1'b0;
      align_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!rst_n) begin
      state_q    <= FETCH;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_instr) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc_q;
      end else if (drop_instr) begin
        instr_q <= NOP_INSTR;
      end
    end
  end

  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset/wrap
// sequences and a randomized run against a behavioural model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
  localparam logic [31:0] I3 = 32'h0040_0213, I4 = 32'h0050_0293, I5 = 32'h0060_0313;
  localparam logic [31:0] I6 = 32'h0070_0393, JK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_q, pc_plus4, pc_next, imem_addr, imem_rdata;
  logic        imem_req, imem_ack, instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, redirect_target, trap_vector;
  logic        redirect_valid, trap_valid, halt, align_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // PC register owned by the core: loads pc_next every cycle.
  always @(posedge clk) pc_q <= pc_next;
  assign pc_plus4 = pc_q + 32'd4;

  fetch_sequencer #(.RESET_VECTOR(RV), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_q(pc_q), .pc_plus4(pc_plus4), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .halt(halt), .align_err(align_err)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rtgt;
    logic        trap;
    logic [31:0] tvec;
    logic        halt;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_next;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_aerr;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_vector = '0; halt = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state for the randomized run.
  logic        m_held, m_halted, m_pend_v, m_pend_trap;
  logic [31:0] m_pend, m_pc, m_instr, m_ipc;

  task automatic model_reset();
    m_held = 1'b0; m_halted = 1'b0; m_pend_v = 1'b0; m_pend_trap = 1'b0;
    m_pend = '0; m_pc = RV; m_instr = NOP; m_ipc = '0;
  endtask

  initial begin
    logic        e_req, e_aerr, has_new;
    logic [31:0] e_next, new_tgt;

    // Directed table: starts in the first cycle after reset release, pc_q = RV.
    //              ack  rdata  rdy  redir rtgt          trap tvec          hlt | req  addr          next          vld  instr ipc           aerr
    vecs[0]  = '{1'b1, I0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8000_0004, 1'b1, I0,    32'h8000_0000, 1'b0};
    vecs[2]  = '{1'b1, I1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0004, 32'h8000_0004, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8000_0008, 1'b1, I1,    32'h8000_0004, 1'b0};
    vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0008, 32'h8000_0008, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0008, 32'h8000_0008, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0008, 32'h8000_0008, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, I2, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0008, 32'h8000_0008, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8000_0008, 1'b1, I2,    32'h8000_0008, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h8000_000C, 1'b1, I2,    32'h8000_0008, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0,    1'b0, 1'b1, 32'h8000_000C, 32'h8000_000C, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_000C, 32'h8000_000C, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[12] = '{1'b1, JK, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_000C, 32'h8000_0100, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[13] = '{1'b1, I3, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0100, 32'h8000_0100, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0200, 1'b0, 1'b0, 32'h0,   32'h8000_0200, 1'b1, I3,    32'h8000_0100, 1'b0};
    vecs[15] = '{1'b1, I4, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0200, 32'h8000_0200, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[16] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0102, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        32'h8000_0100, 1'b1, I4,    32'h8000_0200, 1'b1};
    vecs[17] = '{1'b1, I5, 1'b1, 1'b1, 32'h8000_0400, 1'b0, 32'h0,       1'b0, 1'b1, 32'h8000_0100, 32'h8000_0400, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[18] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b1, 32'h8000_0501, 1'b0, 1'b1, 32'h8000_0400, 32'h8000_0400, 1'b0, 32'h0, 32'h0,       1'b1};
    vecs[19] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0600, 1'b0, 32'h0,    1'b0, 1'b1, 32'h8000_0400, 32'h8000_0400, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[20] = '{1'b1, JK, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8000_0400, 32'h8000_0500, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[21] = '{1'b1, I6, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h8000_0500, 32'h8000_0500, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[22] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0,     1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h8000_0504, 1'b1, I6,    32'h8000_0500, 1'b0};
    vecs[23] = '{1'b1, JK, 1'b1, 1'b1, 32'h8000_0701, 1'b1, 32'h8000_0800, 1'b0, 1'b0, 32'h0,      32'h8000_0504, 1'b0, 32'h0, 32'h0,        1'b0};
    vecs[24] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0700, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,        32'h8000_0504, 1'b0, 32'h0, 32'h0,        1'b0};

    // Reset with an ack and a misaligned redirect pending on the inputs.
    drive_idle();
    rst_n = 1'b0; imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h8000_0103;
    repeat (2) next_cycle();
    check("rst_pc_next", pc_next, RV);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_align_err", {31'b0, align_err}, 32'd0);
    drive_idle();
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; instr_ready = vecs[i].ready;
      redirect_valid = vecs[i].redir; redirect_target = vecs[i].rtgt;
      trap_valid = vecs[i].trap; trap_vector = vecs[i].tvec; halt = vecs[i].halt;
      #1;
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_pc_next", i), pc_next, vecs[i].e_next);
      check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
        check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
      end
      check($sformatf("v%0d_align_err", i), {31'b0, align_err}, {31'b0, vecs[i].e_aerr});
      next_cycle();
    end
    drive_idle();
    next_cycle();
    check("halted_pc_frozen", pc_q, 32'h8000_0504);
    check("halted_no_req", {31'b0, imem_req}, 32'd0);

    // Reset from HALTED with a stray ack: restart fetching at the reset vector.
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = JK;
    #1;
    check("rst2_req_low", {31'b0, imem_req}, 32'd0);
    next_cycle();
    rst_n = 1'b1; imem_ack = 1'b0;
    #1;
    check("rst2_addr", imem_addr, RV);
    check("rst2_req", {31'b0, imem_req}, 32'd1);
    check("rst2_no_valid", {31'b0, instr_valid}, 32'd0);

    // Address wrap: redirect to the last word, consume, next PC wraps to 0.
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    #1;
    check("wrap_redirect_next", pc_next, 32'hFFFF_FFFC);
    next_cycle();
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = I5;
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    imem_ack = 1'b0; instr_ready = 1'b1;
    #1;
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc_next", pc_next, 32'h0);
    next_cycle();
    drive_idle();
    #1;
    check("wrap_fetch_addr", imem_addr, 32'h0);

    // Randomized run against the behavioural model.
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      imem_ack        = ($urandom_range(0, 1) == 0);
      imem_rdata      = $urandom;
      instr_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom;
      trap_valid      = ($urandom_range(0, 15) == 0);
      trap_vector     = $urandom;
      halt            = ($urandom_range(0, 19) == 0);
      rst_n           = !(m_halted && ($urandom_range(0, 3) == 0));

      e_req = 1'b0; e_aerr = 1'b0; e_next = m_pc;
      if (!rst_n) begin
        e_next = RV;
      end else if (m_halted) begin
        e_next = m_pc;
      end else if (m_held) begin
        if (trap_valid || redirect_valid) begin
          new_tgt = trap_valid ? trap_vector : redirect_target;
          e_next  = new_tgt & ~32'd3;
          e_aerr  = (new_tgt % 4) != 0;
        end else if (instr_ready) begin
          e_next = m_pc + 32'd4;
        end
      end else begin
        e_req   = 1'b1;
        has_new = trap_valid || (redirect_valid && !(m_pend_v && m_pend_trap));
        new_tgt = trap_valid ? trap_vector : redirect_target;
        e_aerr  = has_new && ((new_tgt % 4) != 0);
        if (imem_ack && has_new)       e_next = new_tgt & ~32'd3;
        else if (imem_ack && m_pend_v) e_next = m_pend;
      end

      #1;
      check("rnd_pc_next", pc_next, e_next);
      check("rnd_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("rnd_addr", imem_addr, m_pc);
      check("rnd_valid", {31'b0, instr_valid}, {31'b0, m_held});
      if (m_held) begin
        check("rnd_instr", instr, m_instr);
        check("rnd_instr_pc", instr_pc, m_ipc);
      end
      check("rnd_align_err", {31'b0, align_err}, {31'b0, e_aerr});

      if (!rst_n) begin
        model_reset();
      end else if (!m_halted) begin
        if (m_held) begin
          if (trap_valid || redirect_valid || instr_ready) begin
            m_held = 1'b0;
            m_halted = !(trap_valid || redirect_valid) && halt;
          end
        end else if (imem_ack) begin
          if (!has_new && !m_pend_v) begin
            m_held = 1'b1; m_instr = imem_rdata; m_ipc = m_pc;
          end
          m_pend_v = 1'b0; m_pend_trap = 1'b0;
        end else if (has_new) begin
          m_pend_v = 1'b1; m_pend_trap = trap_valid; m_pend = new_tgt & ~32'd3;
        end
        m_pc = e_next;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
